nor_exhaustive_checker: RTL and testbench
=========================================

# nor_exhaustive_checker

Parametrised self-checking harness block for N-input NOR logic. It steps a registered input vector through all 2^N combinations and holds each one for a programmable number of cycles. It compares the device-under-test response against the expected NOR value after a programmable pipeline latency, then reports an error count, the first failing vector and a pass flag. It sits beside the lab gate modules on the FPGA board and replaces free-running toggle stimulus with a synthesisable, clocked, exhaustive check.

## Interface
- N, default 3: DUT input count; legal 1..8.
- HOLD, default 1: cycles each vector is held; legal 1..255.
- LAT, default 0: DUT response latency in cycles; legal 0..7.

- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- VEC  output  N  stimulus to DUT inputs; bit 0 toggles fastest.
- DUT_Y  input  1  DUT output.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE until the next start or rst.
- pass  output  1  high in DONE when err_count == 0.
- err_count  output  N+1  number of mismatching vectors.
- first_err_vec  output  N  first failing vector; valid when err_count != 0.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- rst (any state, including mid-sweep): state goes to IDLE. VEC, busy, done, pass, err_count, first_err_vec, hold counter and the sample pipeline all clear to 0.
- IDLE/DONE + start: go to RUN. VEC=0, hold_cnt=0, err_count=0, first_err_vec=0, done=0, pass=0, busy=1.
- start in RUN or DRAIN is ignored.
- RUN: hold_cnt increments each cycle.
  - At hold_cnt == HOLD-1, a sample tag {valid=1, VEC} enters the delay pipe and hold_cnt returns to 0.
  - At the same point VEC increments. At VEC == 2^N-1 it does not wrap: the state goes to DRAIN if LAT > 0, otherwise to DONE.
- Delay pipe: LAT stages of {valid, vec}; with LAT=0 the tag is used in the same cycle.
- Compare: when the pipe output is valid, expected = ~|vec. On DUT_Y != expected, err_count increments. If err_count was 0, first_err_vec captures that vec.
- Only the last cycle of each hold window is checked, so DUT settling glitches earlier in the window are not errors.
- DRAIN: lasts exactly LAT cycles, during which the pipe empties and compares continue. Then go to DONE.
- DONE: busy=0, done=1, pass=(err_count==0). VEC holds 2^N-1. Outputs are stable until start or rst.
- Width: err_count is N+1 bits, so its maximum of 2^N fits without saturation logic.

## Timing
- Edge k samples start=1. From k+1: busy=1, VEC=0.
- RUN occupies 2^N·HOLD cycles. VEC advances every HOLD cycles.
- The compare for a vector presented at edge e uses DUT_Y sampled at edge e+HOLD-1+LAT. err_count updates at the following edge.
- done=1 and pass valid from edge k+1+2^N·HOLD+LAT. This is also the edge where busy falls.
- Back-to-back: start held high in DONE restarts on the next edge, with done low from that edge.
- start and rst together: rst wins.

## Test plan
- N=3, HOLD=1, LAT=0, correct combinational NOR DUT, pulse start at edge 2:
  - VEC steps 0..7 on edges 3..10.
  - busy falls and done rises at edge 11.
  - pass=1, err_count=0.
- Same setup, DUT stuck-at-0 -> err_count=1, first_err_vec=3'b000, pass=0.
- Same setup, DUT is OR instead of NOR -> err_count=8 (max, no wrap), first_err_vec=0, pass=0.
- N=4, HOLD=4, LAT=2, DUT is NOR plus a 2-flop pipeline that outputs garbage on the first hold cycle of each vector -> pass=1, done at start+1+64+2.
- Reset at VEC=5 mid-RUN -> next edge: all outputs 0, state IDLE. A new start gives a clean full sweep with correct counts.
- start pulsed during RUN and DRAIN -> ignored; sweep length and results are unchanged.

Source files
------------

// File: rtl/nor_exhaustive_checker_if.sv
// nor_exhaustive_checker_if
// Bundles the stimulus/response and result signals of nor_exhaustive_checker.
//   N              : DUT input count (1..8)
//   start          : begin a sweep (checker input)
//   VEC[N-1:0]     : stimulus vector driven to the DUT inputs
//   DUT_Y          : DUT output returned to the checker
//   busy           : sweep in progress (RUN or DRAIN)
//   done           : sweep finished, results valid
//   pass           : done with no mismatches
//   err_count[N:0] : number of mismatching vectors
//   first_err_vec  : first failing vector, valid when err_count != 0
// master = checker side, slave = board/testbench side.
interface nor_exhaustive_checker_if #(
  parameter int N = 3
);
  logic         start;
  logic [N-1:0] VEC;
  logic         DUT_Y;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   err_count;
  logic [N-1:0] first_err_vec;

  modport master (
    input  start, DUT_Y,
    output VEC, busy, done, pass, err_count, first_err_vec
  );

  modport slave (
    output start, DUT_Y,
    input  VEC, busy, done, pass, err_count, first_err_vec
  );
endinterface

// File: rtl/nor_exhaustive_checker.sv
// nor_exhaustive_checker
// Steps VEC through all 2^N input combinations, holding each for HOLD cycles,
// and checks DUT_Y against the N-input NOR of the vector LAT cycles after the
// last cycle of each hold window. Reports a mismatch count, the first failing
// vector and a pass flag once the sweep (plus pipeline drain) completes.
//   Parameters: N (1..8), HOLD (1..255), LAT (0..7)
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : nor_exhaustive_checker_if master modport (start, VEC, DUT_Y,
//         busy, done, pass, err_count, first_err_vec)
module nor_exhaustive_checker #(
  parameter int N    = 3,
  parameter int HOLD = 1,
  parameter int LAT  = 0
) (
  input logic                      clk,
  input logic                      rst,
  nor_exhaustive_checker_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state;
  state_t       next_state;

  logic [7:0]   hold_cnt;
  logic [2:0]   drain_cnt;
  logic [N-1:0] vec_q;
  logic [N:0]   err_q;
  logic [N-1:0] first_q;

  logic         window_end;
  logic         last_vec;
  logic         start_sweep;

  // Tag leaving the delay pipe: the vector whose response is due this cycle.
  logic         tag_valid;
  logic [N-1:0] tag_vec;

  // Only the final cycle of each hold window produces a sample tag, so DUT
  // settling glitches earlier in the window never reach the comparator.
  assign window_end = (state == RUN) && (hold_cnt == 8'(HOLD - 1));
  assign last_vec   = &vec_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and status outputs. start is only honoured in IDLE/DONE.
  always_comb begin
    next_state  = state;
    start_sweep = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.pass    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          next_state  = RUN;
          start_sweep = 1'b1;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        // The last vector does not wrap; it is held until the next start.
        if (window_end && last_vec) begin
          next_state = (LAT > 0) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        bus.busy = 1'b1;
        if (drain_cnt == 3'(LAT - 1)) begin
          next_state = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        bus.pass = (err_q == '0);
        if (bus.start) begin
          next_state  = RUN;
          start_sweep = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Stimulus stepping, drain timing and result accumulation.
  always_ff @(posedge clk) begin
    if (rst || start_sweep) begin
      vec_q     <= '0;
      hold_cnt  <= '0;
      drain_cnt <= '0;
      err_q     <= '0;
      first_q   <= '0;
    end else begin
      if (state == RUN) begin
        if (window_end) begin
          hold_cnt <= '0;
          if (!last_vec) begin
            vec_q <= vec_q + 1'b1;
          end
        end else begin
          hold_cnt <= hold_cnt + 8'd1;
        end
      end
      if (state == DRAIN) begin
        drain_cnt <= drain_cnt + 3'd1;
      end
      // err_q is N+1 bits wide, so 2^N mismatches fit without saturation.
      if (tag_valid && (bus.DUT_Y != ~|tag_vec)) begin
        err_q <= err_q + 1'b1;
        if (err_q == '0) begin
          first_q <= tag_vec;
        end
      end
    end
  end

  // Sample-tag delay pipe matching the DUT response latency.
  generate
    if (LAT == 0) begin : g_no_pipe
      assign tag_valid = window_end;
      assign tag_vec   = vec_q;
    end else begin : g_pipe
      logic         pipe_valid [LAT];
      logic [N-1:0] pipe_vec   [LAT];

      // Shift one stage per cycle in every state so DRAIN empties the pipe.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LAT; i++) begin
            pipe_valid[i] <= 1'b0;
            pipe_vec[i]   <= '0;
          end
        end else begin
          pipe_valid[0] <= window_end;
          pipe_vec[0]   <= vec_q;
          for (int i = 1; i < LAT; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_vec[i]   <= pipe_vec[i-1];
          end
        end
      end

      assign tag_valid = pipe_valid[LAT-1];
      assign tag_vec   = pipe_vec[LAT-1];
    end
  endgenerate

  assign bus.VEC           = vec_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_vec = first_q;

endmodule

// File: tb/tb_nor_exhaustive_checker.sv
// tb_nor_exhaustive_checker
// Drives two checker instances from one clock:
//   inst 0: N=3, HOLD=1, LAT=0 with a combinational bench DUT
//   inst 1: N=4, HOLD=4, LAT=2 with a 2-flop pipelined bench DUT that emits
//           a random bit on the first cycle of every new vector
// The bench DUTs can be correct NOR, stuck-at-0, OR, or NOR with a random
// per-vector fault mask. Expected results come from sweeping the whole
// vector space in a function; expected timing from the sweep arithmetic.
module tb_nor_exhaustive_checker;

  logic clk;
  logic rst;
  int   edge_cnt = 0;
  int   total    = 0;
  int   bad      = 0;

  int          mode_a = 0;
  logic [15:0] mask_a = '0;
  int          mode_b = 0;
  logic [15:0] mask_b = '0;

  logic       y1_b;
  logic       y2_b;
  logic       garbage_b;
  logic [3:0] vec_prev_b;

  nor_exhaustive_checker_if #(.N(3)) bus_a ();
  nor_exhaustive_checker_if #(.N(4)) bus_b ();

  nor_exhaustive_checker #(.N(3), .HOLD(1), .LAT(0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  nor_exhaustive_checker #(.N(4), .HOLD(4), .LAT(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Bench DUT behaviour: mode 0 NOR, 1 stuck-at-0, 2 OR, 3 NOR with fault mask.
  function automatic logic dut_fn(input int mode, input logic [15:0] mask, input int v);
    case (mode)
      0:       return (v == 0);
      1:       return 1'b0;
      2:       return (v != 0);
      default: return (v == 0) ^ mask[v];
    endcase
  endfunction

  always_comb begin
    bus_a.DUT_Y = dut_fn(mode_a, mask_a, int'(bus_a.VEC));
  end

  always @(posedge clk) begin
    y1_b       <= dut_fn(mode_b, mask_b, int'(bus_b.VEC));
    y2_b       <= y1_b;
    vec_prev_b <= bus_b.VEC;
    garbage_b  <= 1'($urandom);
  end

  assign bus_b.DUT_Y = (bus_b.VEC != vec_prev_b) ? garbage_b : y2_b;

  // Reference: the checker counts every vector whose DUT value differs from
  // the N-input NOR (true only for the all-zero vector).
  function automatic void ref_sweep(input int n, input int mode, input logic [15:0] mask,
                                    output int errs, output int first);
    errs  = 0;
    first = 0;
    for (int v = 0; v < (1 << n); v++) begin
      if (dut_fn(mode, mask, v) != (v == 0)) begin
        if (errs == 0) first = v;
        errs++;
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int inst, input logic value);
    if (inst == 0) bus_a.start = value;
    else           bus_b.start = value;
  endtask

  function automatic logic [31:0] get_vec(input int inst);
    return (inst == 0) ? 32'(bus_a.VEC) : 32'(bus_b.VEC);
  endfunction
  function automatic logic [31:0] get_busy(input int inst);
    return (inst == 0) ? 32'(bus_a.busy) : 32'(bus_b.busy);
  endfunction
  function automatic logic [31:0] get_done(input int inst);
    return (inst == 0) ? 32'(bus_a.done) : 32'(bus_b.done);
  endfunction
  function automatic logic [31:0] get_pass(input int inst);
    return (inst == 0) ? 32'(bus_a.pass) : 32'(bus_b.pass);
  endfunction
  function automatic logic [31:0] get_err(input int inst);
    return (inst == 0) ? 32'(bus_a.err_count) : 32'(bus_b.err_count);
  endfunction
  function automatic logic [31:0] get_first(input int inst);
    return (inst == 0) ? 32'(bus_a.first_err_vec) : 32'(bus_b.first_err_vec);
  endfunction

  task automatic check_zero(input int inst);
    checkOutput("zero_vec",   get_vec(inst),   0);
    checkOutput("zero_busy",  get_busy(inst),  0);
    checkOutput("zero_done",  get_done(inst),  0);
    checkOutput("zero_pass",  get_pass(inst),  0);
    checkOutput("zero_err",   get_err(inst),   0);
    checkOutput("zero_first", get_first(inst), 0);
  endtask

  // Full sweep from the current negedge (checker in IDLE or DONE). start is
  // raised after edge k and sampled at k+1; VEC=0 is visible from k+1 and
  // done rises at k+1+2^N*HOLD+LAT. With poke set, random start pulses are
  // driven throughout RUN/DRAIN and must be ignored.
  task automatic run_sweep(input int inst, input bit poke);
    int n, hold, lat, span, maxv, k, errs, first, exp_vec;
    n    = (inst == 0) ? 3 : 4;
    hold = (inst == 0) ? 1 : 4;
    lat  = (inst == 0) ? 0 : 2;
    span = (1 << n) * hold;
    maxv = (1 << n) - 1;
    if (inst == 0) ref_sweep(n, mode_a, mask_a, errs, first);
    else           ref_sweep(n, mode_b, mask_b, errs, first);
    k = edge_cnt;
    applyStimulus(inst, 1'b1);
    for (int c = 1; c <= span + lat; c++) begin
      @(posedge clk);
      #1;
      applyStimulus(inst, poke ? 1'($urandom_range(0, 1)) : 1'b0);
      @(negedge clk);
      exp_vec = (c <= span) ? (c - 1) / hold : maxv;
      checkOutput("run_vec",  get_vec(inst),  32'(exp_vec));
      checkOutput("run_busy", get_busy(inst), 1);
      checkOutput("run_done", get_done(inst), 0);
    end
    @(posedge clk);
    #1;
    applyStimulus(inst, 1'b0);
    @(negedge clk);
    checkOutput("done_edge", 32'(edge_cnt), 32'(k + 1 + span + lat));
    checkOutput("done_flag", get_done(inst),  1);
    checkOutput("done_busy", get_busy(inst),  0);
    checkOutput("done_vec",  get_vec(inst),   32'(maxv));
    checkOutput("err_count", get_err(inst),   32'(errs));
    checkOutput("first_err", get_first(inst), 32'(first));
    checkOutput("pass",      get_pass(inst),  32'(errs == 0));
    repeat (2) @(negedge clk);
    checkOutput("hold_done", get_done(inst), 1);
    checkOutput("hold_err",  get_err(inst),  32'(errs));
    checkOutput("hold_vec",  get_vec(inst),  32'(maxv));
  endtask

  initial begin
    int found;
    rst         = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero(0);
    check_zero(1);

    // Small instance: correct NOR, stuck-at-0, OR (max count), then random faults.
    mode_a = 0;
    run_sweep(0, 1'b0);
    mode_a = 1;
    run_sweep(0, 1'b0);
    mode_a = 2;
    run_sweep(0, 1'b1);
    mode_a = 3;
    for (int i = 0; i < 4; i++) begin
      mask_a = 16'($urandom_range(0, 255));
      run_sweep(0, i[0]);
    end

    // Pipelined instance with first-cycle garbage.
    mode_b = 0;
    mask_b = '0;
    run_sweep(1, 1'b0);
    run_sweep(1, 1'b1);
    mode_b = 3;
    for (int i = 0; i < 3; i++) begin
      mask_b = 16'($urandom);
      run_sweep(1, 1'b1);
    end

    // Reset mid-sweep once VEC reaches 5.
    mode_a = 0;
    found  = 0;
    applyStimulus(0, 1'b1);
    for (int c = 0; c < 40 && found == 0; c++) begin
      @(posedge clk);
      #1;
      applyStimulus(0, 1'b0);
      @(negedge clk);
      if (bus_a.VEC == 3'd5) found = 1;
    end
    checkOutput("reach_vec5", 32'(found), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero(0);
    @(negedge clk);
    checkOutput("idle_busy", get_busy(0), 0);
    checkOutput("idle_vec",  get_vec(0),  0);

    // rst and start in the same cycle: rst wins and the checker stays idle.
    rst = 1'b1;
    applyStimulus(0, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(0, 1'b0);
    @(negedge clk);
    checkOutput("rst_wins_busy", get_busy(0), 0);
    checkOutput("rst_wins_vec",  get_vec(0),  0);
    checkOutput("rst_wins_done", get_done(0), 0);

    // Clean sweeps after reset.
    run_sweep(0, 1'b0);
    mode_a = 1;
    run_sweep(0, 1'b1);
    run_sweep(1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
